if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Pipeline register and hazard control between instruction fetch and decode.
- Captures decoded fetch fields each cycle and presents them to decode/register read.
- Detects load-use hazards against the instruction in ID/EX; on a hazard it stalls the PC and injects a bubble.
- Handles flushes from exception return or redirect, and external multi-cycle stalls.

Parameters:
- NOP_OPCODE, 6'h15, opcode driven on d_opcode for a bubble or after reset.
- STALL_MAX, 1, maximum consecutive load-use stall cycles per hazard.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- f_opcode  in  6  fetch OpCode.
- f_function  in  6  fetch Function (ALU/FPU-selected).
- f_rs1  in  5  fetch Rs1.
- f_rs2  in  5  fetch Rs2.
- f_rd  in  5  fetch Rd.
- f_imm  in  16  fetch Immediate.
- f_pc8  in  32  fetch PCPlusEight.
- flush  in  1  squash the instruction entering IF/ID this edge.
- ext_stall  in  1  downstream multi-cycle unit busy; hold everything.
- ex_mem_read  in  1  instruction currently in ID/EX is a load.
- ex_rd  in  5  destination register of the ID/EX instruction.
- pc_hold  out  1  fetch must not advance PC this cycle (combinational).
- id_bubble  out  1  ID/EX must latch a NOP this cycle (combinational).
- d_valid  out  1  IF/ID holds a real instruction.
- d_opcode, d_function  out  6 each  registered fields.
- d_rs1, d_rs2, d_rd  out  5 each  registered fields.
- d_imm  out  16  registered field.
- d_pc8  out  32  registered field.

Behaviour:
- Reset (asynchronous): d_valid=0, d_opcode=NOP_OPCODE, all other d_* fields=0, FSM=RUN, pc_hold=0, id_bubble=0.
- Latency: one cycle from f_* inputs to d_* outputs.
- uses_rs2 = (d_opcode==6'h00 or 6'h01) or (d_opcode[0:2]==3'b101).
- Store encoding: opcode[0:2]=3'b101 denotes a store.
- hazard = d_valid & ex_mem_read & (ex_rd!=0) & ((ex_rd==d_rs1) | (uses_rs2 & ex_rd==d_rs2)) & (FSM==RUN).
- FSM state RUN:
  - hazard → STALL.
  - Hazard cycle actions: pc_hold=1, id_bubble=1, IF/ID contents held.
- FSM state STALL:
  - Counts stall cycles; the hazard term is masked.
  - Returns to RUN after STALL_MAX cycles. IF/ID loads normally on the cycle it returns.
- Edge priority, highest first:
  1. reset.
  2. flush: d_valid←0, d_opcode←NOP_OPCODE, other fields←0, FSM←RUN. Flush overrides ext_stall and hazard.
  3. ext_stall: all registers and FSM hold; pc_hold=1; id_bubble=0.
  4. hazard: hold as above.
  5. Otherwise load f_* and set d_valid←1.
- ext_stall during STALL freezes the stall counter.
- pc_hold = ext_stall | hazard. It is never asserted during flush.
- Register 0 as a load destination never causes a stall.
- Reset mid-stall returns immediately to RUN with a bubble in IF/ID.

Optional Feature:
- Macro IF_ID_PERF_CNT_EN.
- When defined, adds outputs stall_cnt[32] and flush_cnt[32]. Both are 0 on reset, saturate at 32'hFFFFFFFF, and are not cleared by flush.
  - stall_cnt increments on each cycle with pc_hold=1.
  - flush_cnt increments on each flush edge.
- When undefined, the outputs and counters do not exist; no other behaviour changes.

Decomposition:
- Shared package holds:
  - opcode constants: NOP 6'h15, RTYPE 6'h00, FTYPE 6'h01, store prefix 3'b101.
  - FSM state encoding: RUN=0, STALL=1.
  - register-index width (5) and data width (32).
- Sub-module load_use_detect: combinational hazard compare (d_* fields, ex_mem_read, ex_rd → hazard_raw).
- if_id_stage owns the registers, the FSM and the optional counters.

Test Plan:
- Reset, then f_opcode=6'h08, f_rs1=3, f_imm=16'h0010, f_pc8=32'h8 → next edge d_valid=1, d_opcode=6'h08, d_imm=16'h0010, d_pc8=32'h8.
- Load-use: IF/ID holds add r4,r2,r5 (opcode 0, rs1=2, rs2=5); ex_mem_read=1, ex_rd=5 → pc_hold=1 and id_bubble=1 for exactly one cycle, IF/ID unchanged, then loads the next instruction.
- Immediate-type ALU op (opcode 6'h08, rs2 field=5) with ex_mem_read=1, ex_rd=5 → no stall. With ex_rd=0 and rs1=0 → no stall.
- ext_stall held 3 cycles while the f_* inputs change → d_* frozen, pc_hold=1 each cycle, id_bubble=0.
- flush asserted together with ext_stall and a hazard → next edge d_valid=0, d_opcode=6'h15, FSM=RUN, pc_hold=0.
- With IF_ID_PERF_CNT_EN: one hazard, two ext_stall cycles and one flush → stall_cnt=3, flush_cnt=1. Asynchronous reset mid-run → both counters 0.

Source files
------------

// File: rtl/if_id_stage_pkg.sv
// Shared encodings for the IF/ID pipeline register and its hazard logic.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package if_id_stage_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [5:0] OP_NOP       = 6'h15;
  localparam logic [5:0] OP_RTYPE     = 6'h00;
  localparam logic [5:0] OP_FTYPE     = 6'h01;
  // Stores are identified by the three most significant opcode bits.
  localparam logic [2:0] OP_STORE_PFX = 3'b101;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // Decoded fetch fields carried through the IF/ID register.
  typedef struct packed {
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [15:0]       imm;
    logic [DATA_W-1:0] pc8;
  } id_fields_t;

  // Register-register ALU/FPU ops and stores read rs2; everything else
  // treats the rs2 field as don't-care.
  function automatic logic uses_rs2(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_FTYPE) || (op[5:3] == OP_STORE_PFX);
  endfunction

endpackage

// File: rtl/if_id_stage_load_use_detect.sv
// Load-use compare between the instruction in IF/ID and a load in ID/EX.
// Latency: purely combinational.
// Backpressure: none; the caller masks the result with its FSM state.
module load_use_detect
  import if_id_stage_pkg::*;
(
  input  logic             d_valid,
  input  logic [5:0]       d_opcode,
  input  logic [REG_W-1:0] d_rs1,
  input  logic [REG_W-1:0] d_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  output logic             hazard_raw
);

  logic rs1_match;
  logic rs2_match;

  // r0 is hardwired, so a load targeting it never creates a dependency.
  always_comb begin
    rs1_match  = (ex_rd == d_rs1);
    rs2_match  = uses_rs2(d_opcode) && (ex_rd == d_rs2);
    hazard_raw = d_valid && ex_mem_read && (ex_rd != '0) && (rs1_match || rs2_match);
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall, flush and external stall control.
// Latency: one cycle from f_* to d_*; pc_hold/id_bubble are combinational.
// Backpressure: ext_stall or a load-use hazard freezes IF/ID and holds the PC; flush wins over both.
// Optional: define IF_ID_PERF_CNT_EN to add saturating stall_cnt/flush_cnt outputs.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [5:0] NOP_OPCODE = OP_NOP,
  parameter int         STALL_MAX  = 1
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        f_opcode,
  input  logic [5:0]        f_function,
  input  logic [REG_W-1:0]  f_rs1,
  input  logic [REG_W-1:0]  f_rs2,
  input  logic [REG_W-1:0]  f_rd,
  input  logic [15:0]       f_imm,
  input  logic [DATA_W-1:0] f_pc8,
  input  logic              flush,
  input  logic              ext_stall,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_rd,
  output logic              pc_hold,
  output logic              id_bubble,
  output logic              d_valid,
  output logic [5:0]        d_opcode,
  output logic [5:0]        d_function,
  output logic [REG_W-1:0]  d_rs1,
  output logic [REG_W-1:0]  d_rs2,
  output logic [REG_W-1:0]  d_rd,
  output logic [15:0]       d_imm,
  output logic [DATA_W-1:0] d_pc8
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam int CW = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;

  id_fields_t    id_q;
  id_fields_t    f_in;
  id_fields_t    bubble;
  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          hazard_raw;
  logic          hazard;
  logic          load_en;

  assign f_in   = '{opcode: f_opcode, funct: f_function, rs1: f_rs1, rs2: f_rs2,
                    rd: f_rd, imm: f_imm, pc8: f_pc8};
  assign bubble = '{opcode: NOP_OPCODE, default: '0};

  load_use_detect u_load_use_detect (
    .d_valid     (d_valid),
    .d_opcode    (id_q.opcode),
    .d_rs1       (id_q.rs1),
    .d_rs2       (id_q.rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .hazard_raw  (hazard_raw)
  );

  // Stall FSM state and stall-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, IF/ID load enable and hold/bubble outputs by edge priority.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_en   = 1'b0;
    hazard    = hazard_raw && (state == ST_RUN);
    pc_hold   = !flush && (ext_stall || hazard);
    id_bubble = !flush && !ext_stall && hazard;
    if (flush) begin
      state_nxt = ST_RUN;
      cnt_nxt   = '0;
    end else if (ext_stall) begin
      // Everything, including the stall counter, is frozen.
      state_nxt = state;
    end else if (hazard) begin
      state_nxt = ST_STALL;
      cnt_nxt   = '0;
    end else if (state == ST_STALL) begin
      if (cnt == CW'(STALL_MAX - 1)) begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
        load_en   = 1'b1;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end else begin
      load_en = 1'b1;
    end
  end

  // IF/ID register: flush squashes to a bubble, otherwise load when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_q    <= bubble;
      d_valid <= 1'b0;
    end else if (flush) begin
      id_q    <= bubble;
      d_valid <= 1'b0;
    end else if (load_en) begin
      id_q    <= f_in;
      d_valid <= 1'b1;
    end
  end

  assign d_opcode   = id_q.opcode;
  assign d_function = id_q.funct;
  assign d_rs1      = id_q.rs1;
  assign d_rs2      = id_q.rs2;
  assign d_rd       = id_q.rd;
  assign d_imm      = id_q.imm;
  assign d_pc8      = id_q.pc8;

`ifdef IF_ID_PERF_CNT_EN
  // Saturating event counters; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_hold && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (flush && (flush_cnt != 32'hFFFF_FFFF))   flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage.
// Inputs change 1ns after the rising edge; outputs are sampled before the next edge.
// Counter checks are compiled in when IF_ID_PERF_CNT_EN is defined.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  f_opcode, f_function;
  logic [4:0]  f_rs1, f_rs2, f_rd;
  logic [15:0] f_imm;
  logic [31:0] f_pc8;
  logic        flush, ext_stall, ex_mem_read;
  logic [4:0]  ex_rd;
  logic        pc_hold, id_bubble, d_valid;
  logic [5:0]  d_opcode, d_function;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [15:0] d_imm;
  logic [31:0] d_pc8;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk         (clk),
    .reset       (reset),
    .f_opcode    (f_opcode),
    .f_function  (f_function),
    .f_rs1       (f_rs1),
    .f_rs2       (f_rs2),
    .f_rd        (f_rd),
    .f_imm       (f_imm),
    .f_pc8       (f_pc8),
    .flush       (flush),
    .ext_stall   (ext_stall),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .pc_hold     (pc_hold),
    .id_bubble   (id_bubble),
    .d_valid     (d_valid),
    .d_opcode    (d_opcode),
    .d_function  (d_function),
    .d_rs1       (d_rs1),
    .d_rs2       (d_rs2),
    .d_rd        (d_rd),
    .d_imm       (d_imm),
    .d_pc8       (d_pc8)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_f(input logic [5:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [31:0] pc8);
    f_opcode = op; f_function = 6'h20; f_rs1 = rs1; f_rs2 = rs2;
    f_rd = rd; f_imm = imm; f_pc8 = pc8;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; ext_stall = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
    set_f(6'h00, 0, 0, 0, 16'h0, 32'h0);
    tick(); tick();

    // Reset state
    chk("rst_valid", d_valid, 0);
    chk("rst_opcode", d_opcode, 6'h15);
    chk("rst_rs1", d_rs1, 0);
    chk("rst_pc8", d_pc8, 0);
    chk("rst_pc_hold", pc_hold, 0);
    chk("rst_bubble", id_bubble, 0);
    reset = 1'b0;

    // One-cycle capture
    set_f(6'h08, 3, 0, 1, 16'h0010, 32'h8);
    tick();
    chk("ld_valid", d_valid, 1);
    chk("ld_opcode", d_opcode, 6'h08);
    chk("ld_imm", d_imm, 16'h0010);
    chk("ld_pc8", d_pc8, 32'h8);
    chk("ld_rs1", d_rs1, 3);

    // Load-use on rs2 of an R-type add r4,r2,r5
    set_f(6'h00, 2, 5, 4, 16'h0, 32'hC);
    tick();
    set_f(6'h08, 1, 5, 6, 16'h0020, 32'h10);
    ex_mem_read = 1'b1; ex_rd = 5'd5;
    #1;
    chk("lu_pc_hold", pc_hold, 1);
    chk("lu_bubble", id_bubble, 1);
    tick();
    chk("lu_hold_pc8", d_pc8, 32'hC);
    chk("lu_hold_op", d_opcode, 6'h00);
    #1;
    chk("lu_masked_hold", pc_hold, 0);
    chk("lu_masked_bub", id_bubble, 0);
    tick();
    chk("lu_next_pc8", d_pc8, 32'h10);
    chk("lu_next_op", d_opcode, 6'h08);

    // Immediate op: rs2 field matches the load but is not read
    #1;
    chk("imm_no_stall", pc_hold, 0);

    // Load to r0 never stalls even when rs1 is r0
    set_f(6'h00, 0, 0, 7, 16'h0, 32'h14);
    ex_mem_read = 1'b0;
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd0;
    #1;
    chk("r0_no_stall", pc_hold, 0);

    // Store reads rs2 -> hazard; ext_stall during STALL freezes the counter
    set_f(6'h2B, 1, 9, 0, 16'h4, 32'h18);
    ex_mem_read = 1'b0;
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd9;
    set_f(6'h08, 2, 0, 3, 16'h1, 32'h1C);
    #1;
    chk("st_pc_hold", pc_hold, 1);
    chk("st_bubble", id_bubble, 1);
    tick();
    ext_stall = 1'b1; ex_mem_read = 1'b0;
    tick();
    chk("stx_frozen_pc8", d_pc8, 32'h18);
    ext_stall = 1'b0;
    tick();
    chk("stx_resume_pc8", d_pc8, 32'h1C);

    // ext_stall for three cycles with changing fetch inputs
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_f(6'(i + 2), 5'(i), 5'(i), 5'(i), 16'(i), 32'h100 + 32'(i));
      #1;
      chk("xs_pc_hold", pc_hold, 1);
      chk("xs_bubble", id_bubble, 0);
      tick();
      chk("xs_pc8", d_pc8, 32'h1C);
      chk("xs_valid", d_valid, 1);
    end
    ext_stall = 1'b0;

    // Flush together with ext_stall and a live hazard
    set_f(6'h00, 2, 5, 4, 16'h0, 32'h40);
    tick();
    chk("fl_pre_pc8", d_pc8, 32'h40);
    flush = 1'b1; ext_stall = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd2;
    #1;
    chk("fl_pc_hold", pc_hold, 0);
    chk("fl_bubble", id_bubble, 0);
    tick();
    chk("fl_valid", d_valid, 0);
    chk("fl_opcode", d_opcode, 6'h15);
    chk("fl_pc8", d_pc8, 0);
    flush = 1'b0; ext_stall = 1'b0;
    set_f(6'h08, 1, 1, 1, 16'h0, 32'h44);
    #1;
    chk("fl_post_hold", pc_hold, 0);
    tick();
    chk("fl_post_valid", d_valid, 1);
    chk("fl_post_pc8", d_pc8, 32'h44);

    // Reset in the middle of a stall
    set_f(6'h00, 2, 5, 4, 16'h0, 32'h48);
    ex_mem_read = 1'b0;
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd2;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", d_valid, 0);
    chk("mid_rst_opcode", d_opcode, 6'h15);
    tick();
    reset = 1'b0;
    set_f(6'h08, 3, 0, 1, 16'h0, 32'h50);
    #1;
    chk("mid_rst_no_hold", pc_hold, 0);
    tick();
    chk("mid_rst_load", d_pc8, 32'h50);

`ifdef IF_ID_PERF_CNT_EN
    // One hazard cycle, two ext_stall cycles, one flush
    chk("perf_rst_stall", stall_cnt, 0);
    chk("perf_rst_flush", flush_cnt, 0);
    set_f(6'h00, 2, 5, 4, 16'h0, 32'h60);
    ex_mem_read = 1'b0;
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd2;
    tick();
    ex_mem_read = 1'b0; ext_stall = 1'b1;
    tick(); tick();
    ext_stall = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("perf_stall_cnt", stall_cnt, 3);
    chk("perf_flush_cnt", flush_cnt, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("perf_arst_stall", stall_cnt, 0);
    chk("perf_arst_flush", flush_cnt, 0);
    tick();
    reset = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
